// File: rtl/rsenc_ctrl_if.sv
// rsenc_ctrl_if: byte stream in (valid/ready/last) and registered codeword stream out.
//   slave  - controller side: consumes in_*, drives in_ready and out_*
//   master - packetizer/line side: drives in_*, observes in_ready and out_*
interface rsenc_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_parity;
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_parity
  );
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_parity
  );
endinterface

// File: rtl/rsenc_ctrl.sv
// rsenc_ctrl: frame sequencer driving rsenc control/input and registering its codeword output.
//   clk, rst            clock, async active-high reset (rsenc nrst is driven with !rst)
//   io (slave)          input byte stream and registered codeword stream with sop/eop/parity
//   enc_control/enc_in  to rsenc: 1 = data accumulate, 0 = parity shift-out; symbol in
//   enc_out             from rsenc, combinational in enc_in/enc_control
//   underrun/overlong   in-cycle pulses: zero inserted mid-frame / frame cut at K symbols
//   busy                controller is not idle
module rsenc_ctrl #(
  parameter int K = 239,
  parameter int NPAR = 16
) (
  input  logic        clk,
  input  logic        rst,
  rsenc_ctrl_if.slave io,
  output logic        enc_control,
  output logic [7:0]  enc_in,
  input  logic [7:0]  enc_out,
  output logic        underrun,
  output logic        overlong,
  output logic        busy
);
  localparam int DW = $clog2(K + 1);
  localparam int PW = NPAR > 1 ? $clog2(NPAR) : 1;
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2;
  logic [1:0] state;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic start, kth, term, pend;
  // rst gates the idle accept so the encoder sees a zero symbol while held in reset
  assign start = state == IDLE && io.in_valid && !rst;
  assign kth = state == DATA && dcnt == DW'(K - 1);
  assign term = state == DATA && ((io.in_valid && io.in_last) || kth);
  assign pend = state == PARITY && pcnt == PW'(NPAR - 1);
  assign io.in_ready = state != PARITY;
  assign enc_control = state != PARITY;
  // rsenc never stalls: a missing mid-frame symbol is fed as zero
  assign enc_in = (start || (state == DATA && io.in_valid)) ? io.in_data : 8'h00;
  assign underrun = state == DATA && !io.in_valid;
  assign overlong = (start && K == 1 && !io.in_last) || (kth && !(io.in_valid && io.in_last));
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dcnt <= '0;
      pcnt <= '0;
      io.out_valid <= 1'b0;
      io.out_data <= 8'h00;
      io.out_sop <= 1'b0;
      io.out_eop <= 1'b0;
      io.out_parity <= 1'b0;
    end else begin
      state <= start ? ((io.in_last || K == 1) ? PARITY : DATA) : term ? PARITY : pend ? IDLE : state;
      dcnt <= start ? DW'(1) : state == DATA ? dcnt + DW'(1) : dcnt;
      pcnt <= state == PARITY ? (pend ? '0 : pcnt + PW'(1)) : pcnt;
      io.out_valid <= busy || io.in_valid;
      io.out_data <= enc_out;
      io.out_sop <= start;
      io.out_eop <= pend;
      io.out_parity <= state == PARITY;
    end
  end
endmodule

// File: tb/tb_rsenc_ctrl.sv
// tb_rsenc_ctrl: directed and random frames checked against a polynomial-division RS reference.
module tb_rsenc_ctrl;
  localparam int K = 3;
  localparam int NPAR = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rsenc_ctrl_if io();
  logic enc_control, underrun, overlong, busy;
  logic [7:0] enc_in, enc_out;
  rsenc_ctrl #(.K(K), .NPAR(NPAR)) dut (
    .clk(clk), .rst(rst), .io(io),
    .enc_control(enc_control), .enc_in(enc_in), .enc_out(enc_out),
    .underrun(underrun), .overlong(overlong), .busy(busy)
  );
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1d : 8'h00);
    end
    return r;
  endfunction
  logic [7:0] g [0:NPAR];
  // Stand-in rsenc: systematic LFSR encoder, cleared by nrst = !rst.
  logic [7:0] pr [0:NPAR-1];
  logic [7:0] fb;
  assign fb = enc_control ? (enc_in ^ pr[NPAR-1]) : 8'h00;
  assign enc_out = enc_control ? enc_in : pr[NPAR-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPAR; i++) pr[i] <= 8'h00;
    end else begin
      pr[0] <= gmul(fb, g[0]);
      for (int i = 1; i < NPAR; i++) pr[i] <= pr[i-1] ^ gmul(fb, g[i]);
    end
  end
  typedef struct packed {logic [7:0] d; logic sop; logic eop; logic par;} exp_t;
  exp_t expq[$];
  logic [7:0] cur[$];
  int checks = 0, errors = 0;
  int nun, nov, rlow, exp_un, exp_ov, nfr, run, maxrun;
  logic acc;
  logic [7:0] ov_d;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  // Reference: frames close on last or at K symbols; parity = M(x)*x^NPAR mod g(x).
  task automatic note_sym(input logic [7:0] d, input logic last);
    logic [7:0] r[$];
    logic [7:0] c;
    expq.push_back(exp_t'({d, cur.size() == 0, 1'b0, 1'b0}));
    cur.push_back(d);
    if (cur.size() == K && !last) exp_ov++;
    if (last || cur.size() == K) begin
      r = cur;
      for (int j = 0; j < NPAR; j++) r.push_back(8'h00);
      for (int i = 0; i < cur.size(); i++) begin
        c = r[i];
        for (int j = 1; j <= NPAR; j++) r[i+j] ^= gmul(c, g[NPAR-j]);
      end
      for (int j = 0; j < NPAR; j++) expq.push_back(exp_t'({r[cur.size()+j], 1'b0, j == NPAR - 1, 1'b1}));
      cur.delete();
      nfr++;
    end
  endtask
  task automatic pre();
    @(negedge clk);
    acc = io.in_valid && io.in_ready;
    if (!io.in_ready) rlow++;
    if (underrun) nun++;
    if (overlong) begin
      nov++;
      ov_d = io.in_data;
    end
  endtask
  task automatic post();
    exp_t e;
    @(posedge clk);
    #1;
    run = io.out_valid ? run + 1 : 0;
    if (run > maxrun) maxrun = run;
    if (io.out_valid) begin
      check("out_valid_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("out_word", {io.out_data, io.out_sop, io.out_eop, io.out_parity}, {e.d, e.sop, e.eop, e.par});
      end
    end
  endtask
  task automatic gap();
    io.in_valid = 1'b0;
    io.in_last = 1'b0;
    pre();
    if (cur.size() != 0) begin
      exp_un++;
      note_sym(8'h00, 1'b0);
    end
    post();
  endtask
  task automatic send_sym(input logic [7:0] d, input logic last);
    int n = 0;
    io.in_valid = 1'b1;
    io.in_data = d;
    io.in_last = last;
    do begin
      pre();
      if (acc) note_sym(d, last);
      post();
      n++;
    end while (!acc && n < 50);
    check("accepted", acc, 1);
    if (acc) check("latency", {io.out_valid, io.out_data}, {1'b1, d});
    io.in_valid = 1'b0;
    io.in_last = 1'b0;
  endtask
  task automatic begin_test();
    nun = 0; nov = 0; rlow = 0; exp_un = 0; exp_ov = 0; nfr = 0; maxrun = 0;
  endtask
  task automatic end_test();
    int n = 0;
    while ((expq.size() != 0 || cur.size() != 0) && n < 100) begin
      gap();
      n++;
    end
    gap();
    gap();
    check("drain", expq.size(), 0);
    check("underrun_cnt", nun, exp_un);
    check("overlong_cnt", nov, exp_ov);
    check("ready_low_cycles", rlow, nfr * NPAR);
  endtask
  initial begin
    logic [7:0] a;
    int len;
    for (int j = 0; j <= NPAR; j++) g[j] = 8'h00;
    g[0] = 8'h01;
    a = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j >= 1; j--) g[j] = g[j-1] ^ gmul(g[j], a);
      g[0] = gmul(g[0], a);
      a = gmul(a, 8'h02);
    end
    run = 0;
    io.in_valid = 1'b0;
    io.in_data = 8'h00;
    io.in_last = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    io.in_valid = 1'b1;
    io.in_data = 8'hA5;
    #1;
    check("reset_outs", {io.out_valid, io.out_data, io.out_sop, io.out_eop, io.out_parity, underrun, overlong, busy}, 0);
    check("reset_enc", {io.in_ready, enc_control, enc_in}, {1'b1, 1'b1, 8'h00});
    io.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin_test();
    send_sym(8'h12, 1'b0);
    send_sym(8'h34, 1'b0);
    send_sym(8'h56, 1'b1);
    end_test();
    check("frame1_run", maxrun, K + NPAR);
    begin_test();
    send_sym(8'hAB, 1'b1);
    end_test();
    check("single_run", maxrun, 1 + NPAR);
    begin_test();
    send_sym(8'h12, 1'b0);
    send_sym(8'h34, 1'b0);
    send_sym(8'h56, 1'b0);
    send_sym(8'h78, 1'b0);
    send_sym(8'h9A, 1'b1);
    end_test();
    check("overlong_at", ov_d, 8'h56);
    begin_test();
    send_sym(8'h12, 1'b0);
    gap();
    send_sym(8'h56, 1'b1);
    end_test();
    begin_test();
    send_sym(8'h21, 1'b0);
    send_sym(8'h43, 1'b0);
    send_sym(8'h65, 1'b1);
    send_sym(8'h87, 1'b0);
    send_sym(8'hA9, 1'b0);
    send_sym(8'hCB, 1'b1);
    end_test();
    check("b2b_run", maxrun, 2 * (K + NPAR));
    send_sym(8'h12, 1'b0);
    send_sym(8'h34, 1'b0);
    send_sym(8'h56, 1'b1);
    gap();
    rst = 1'b1;
    #1;
    check("midrst_outs", {io.out_valid, io.out_data, io.out_sop, io.out_eop, io.out_parity, underrun, overlong, busy}, 0);
    check("midrst_enc", {io.in_ready, enc_control, enc_in}, {1'b1, 1'b1, 8'h00});
    expq.delete();
    cur.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin_test();
    send_sym(8'h12, 1'b0);
    send_sym(8'h34, 1'b0);
    send_sym(8'h56, 1'b1);
    end_test();
    begin_test();
    repeat (25) begin
      len = $urandom_range(1, K + 2);
      for (int i = 0; i < len; i++) begin
        send_sym(8'($urandom), i == len - 1);
        if (i < len - 1 && $urandom_range(0, 3) == 0) gap();
      end
      repeat ($urandom_range(0, 2)) gap();
    end
    end_test();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rsenc_ctrl.md
# rsenc_ctrl

Frame sequencer for the `rsenc` Reed-Solomon encoder. It accepts a byte stream with valid/ready/last framing and drives `rsenc` control and input symbol by symbol. It switches the encoder to parity shift-out after each frame's data and emits a registered codeword stream with frame markers. It sits between the packetizer and the line interface and is the only driver of `rsenc` control and input.

## Interface
- K, 239: maximum data symbols per codeword; legal range 1..255-NPAR.
- NPAR, 16: parity symbols per codeword; must equal the parity count of the attached `rsenc`.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset. Top level drives `rsenc` nrst with !rst.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  controller accepts the symbol this cycle.
- in_data  in  8  input data symbol.
- in_last  in  1  last data symbol of the frame; qualified by in_valid && in_ready.
- enc_control  out  1  to `rsenc` control: 1 = data pass / accumulate, 0 = parity shift-out.
- enc_in  out  8  to `rsenc` in.
- enc_out  in  8  from `rsenc` out; combinational in enc_in, enc_control and encoder state.
- out_valid  out  1  codeword symbol valid.
- out_data  out  8  codeword symbol.
- out_sop  out  1  first symbol of codeword.
- out_eop  out  1  last parity symbol of codeword.
- out_parity  out  1  symbol is parity.
- underrun  out  1  one-cycle pulse: zero symbol inserted mid-frame.
- overlong  out  1  one-cycle pulse: frame force-terminated at K symbols.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, DATA, PARITY. Counters: dcnt is $clog2(K+1) bits; pcnt is $clog2(NPAR) bits.
- `rsenc` has no stall and shifts every clock, so a started frame is never paused.
- enc_control, enc_in and in_ready are combinational from state and inputs so that `rsenc` sees them in the same cycle.
- IDLE:
  - in_ready=1, enc_control=1, enc_in=0; the encoder state stays zero.
  - On in_valid: enc_in=in_data, dcnt<=1, mark sop.
  - Next state: PARITY if in_last or K==1, else DATA.
- DATA:
  - in_ready=1, enc_control=1.
  - enc_in = in_valid ? in_data : 8'h00. The missing symbol is replaced by a zero, the codeword stays consistent, and underrun pulses.
  - dcnt increments every cycle.
  - Go to PARITY when an accepted in_last arrives or when dcnt==K-1 this cycle.
  - If the K-th symbol lacks in_last, pulse overlong. The next input symbol starts a new frame.
- PARITY:
  - in_ready=0, enc_control=0, enc_in=0.
  - pcnt counts 0..NPAR-1. At NPAR-1, mark eop, clear pcnt and go to IDLE.
  - `rsenc` registers are all-zero after NPAR shift-out cycles, so no reset between frames.
- Shortened frames (L<K data symbols) need no padding: leading zeros leave a zeroed LFSR unchanged, so L symbols give the shortened codeword directly.
- Output register, updated every cycle from the current-cycle values:
  - out_valid <= (state != IDLE) || (in_valid in IDLE).
  - out_data <= enc_out.
  - out_sop, out_eop and out_parity are taken from the state and counters.
  - out_parity=1 for every PARITY cycle.

## Timing
- Reset values: state IDLE, counters 0. All out_* are 0, underrun=0, overlong=0, busy=0.
- During reset, in_ready=1, enc_control=1 and enc_in=0, combinationally.
- Latency: input symbol accepted in cycle n appears on out_data in cycle n+1.
- Codeword of L data symbols: L+NPAR consecutive out_valid cycles with no gaps.
- in_ready is low for exactly NPAR cycles per frame.
- Back-to-back frames: the first symbol of the next frame can be accepted in the cycle after the last parity cycle, giving zero idle cycles on the output.
- Simultaneous in_last and dcnt==K-1: normal termination, no overlong.
- underrun and overlong pulse in the cycle of the event; they are not registered with the output.
- Reset mid-frame:
  - State returns to IDLE immediately and out_valid drops.
  - `rsenc` is cleared through nrst; no partial codeword is completed.

## Test plan
- K=3, NPAR=4; send 12,34,56 with last on 56:
  - out 12,34,56, then 4 parity symbols matching the software RS model.
  - sop on 12, eop on the 4th parity symbol.
  - in_ready low for 4 cycles.
- Single-symbol frame AB with last -> out AB plus 4 parity symbols matching the model for shortened message {AB}; sop and eop in separate cycles.
- Send 12,34,56,78 without last:
  - overlong pulses with 56.
  - 78 is held (in_ready=0) during parity and then starts a new frame with out_sop=1.
- Send 12, drop in_valid for 1 cycle, then 56 with last:
  - underrun pulses once.
  - out 12,00,56 plus parity matching the model for {12,00,56}.
- Two frames back-to-back with in_valid held high -> 14 contiguous out_valid cycles, eop then sop in adjacent cycles, both codewords match the model.
- Assert rst during the 2nd parity cycle:
  - All outputs are 0 immediately.
  - After release, frame 12,34,56 produces correct parity, proving the encoder state was cleared.
